// File: rtl/modexp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : modexp_pkg
//  Purpose  : Shared definitions for the mont_modexp requester front end:
//             FSM state encoding, default widths and the job record.
//  Revision : 1.0  initial release
// ============================================================================
package modexp_pkg;

  // Default operand and tag widths (pending review)
  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_TAG_W = 4;

  // Issue FSM encoding: IDLE -> ISSUE -> WAIT -> HOLD -> IDLE
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Job record at the default widths; the top level builds the same layout
  // from its own parameters so non-default instances stay consistent.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] base;
    logic [DEF_WIDTH-1:0] exp;
    logic [DEF_TAG_W-1:0] tag;
  } job_t;

endpackage : modexp_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with a registered occupancy count. Flags are
//             decoded from the registered count, so a push in the same cycle
//             as a pop on a full FIFO is accepted without changing occupancy.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int unsigned DATA_W = 68,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  // Next pointer and occupancy; pointers wrap naturally (DEPTH is a power of two)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because the count gates reads
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/modexp_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : modexp_initiator
//  Purpose  : Requester-side front end for one mont_modexp instance. Queues
//             tagged (base, exp) jobs, issues them one at a time with a start
//             pulse, waits for done (with optional timeout) and returns the
//             tagged result on a valid/ready stream.
//  Revision : 1.0  initial release
// ============================================================================
module modexp_initiator
  import modexp_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_base,
  input  logic [WIDTH-1:0] in_exp,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_timeout,
  output logic             me_start,
  output logic [WIDTH-1:0] me_base,
  output logic [WIDTH-1:0] me_exp,
  input  logic             me_done,
  input  logic [WIDTH-1:0] me_result,
  output logic             busy,
  output logic [15:0]      jobs_cnt
);

  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] exp;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t fifo_wdata, fifo_rdata;
  logic fifo_full, fifo_empty, fifo_push, fifo_pop;

  logic [1:0]       state_q,       state_d;
  logic [WIDTH-1:0] base_q,        base_d;
  logic [WIDTH-1:0] exp_q,         exp_d;
  logic [TAG_W-1:0] tag_q,         tag_d;
  logic [TMO_W-1:0] tmo_cnt_q,     tmo_cnt_d;
  logic             wait_first_q,  wait_first_d;
  logic             out_valid_q,   out_valid_d;
  logic [WIDTH-1:0] out_result_q,  out_result_d;
  logic [TAG_W-1:0] out_tag_q,     out_tag_d;
  logic             out_timeout_q, out_timeout_d;
  logic [15:0]      jobs_cnt_q,    jobs_cnt_d;
  logic             tmo_hit;

  assign fifo_wdata = '{base: in_base, exp: in_exp, tag: in_tag};
  assign fifo_push  = in_valid && in_ready;
  assign in_ready   = !fifo_full;

  sync_fifo #(
    .DATA_W ($bits(req_t)),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Timeout compare exists only when a non-zero limit is configured
  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
      assign tmo_hit = (tmo_cnt_q == TMO_LAST);
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  // Issue FSM: pop, pulse start, wait for done/timeout, hold result until taken
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    exp_d         = exp_q;
    tag_d         = tag_q;
    tmo_cnt_d     = tmo_cnt_q;
    wait_first_d  = wait_first_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_tag_d     = out_tag_q;
    out_timeout_d = out_timeout_q;
    jobs_cnt_d    = jobs_cnt_q;
    fifo_pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !out_valid_q) begin
          fifo_pop = 1'b1;
          base_d   = fifo_rdata.base;
          exp_d    = fifo_rdata.exp;
          tag_d    = fifo_rdata.tag;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_cnt_d    = '0;
        wait_first_d = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        // A done seen in the first WAIT cycle may be left over from the
        // previous job, so it is not trusted.
        wait_first_d = 1'b0;
        tmo_cnt_d    = tmo_cnt_q + TMO_W'(1);
        if (me_done && !wait_first_q) begin
          out_result_d  = me_result;
          out_tag_d     = tag_q;
          out_timeout_d = 1'b0;
          out_valid_d   = 1'b1;
          jobs_cnt_d    = jobs_cnt_q + 16'd1;
          state_d       = ST_HOLD;
        end else if (tmo_hit) begin
          out_result_d  = '0;
          out_tag_d     = tag_q;
          out_timeout_d = 1'b1;
          out_valid_d   = 1'b1;
          jobs_cnt_d    = jobs_cnt_q + 16'd1;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, operand, result and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      exp_q         <= '0;
      tag_q         <= '0;
      tmo_cnt_q     <= '0;
      wait_first_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
      out_timeout_q <= 1'b0;
      jobs_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      exp_q         <= exp_d;
      tag_q         <= tag_d;
      tmo_cnt_q     <= tmo_cnt_d;
      wait_first_q  <= wait_first_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_tag_q     <= out_tag_d;
      out_timeout_q <= out_timeout_d;
      jobs_cnt_q    <= jobs_cnt_d;
    end
  end

  assign me_start    = (state_q == ST_ISSUE);
  assign me_base     = base_q;
  assign me_exp      = exp_q;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_tag     = out_tag_q;
  assign out_timeout = out_timeout_q;
  assign jobs_cnt    = jobs_cnt_q;
  assign busy        = !fifo_empty || (state_q != ST_IDLE) || out_valid_q;

endmodule : modexp_initiator
`default_nettype wire

// File: tb/tb_modexp_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_modexp_initiator
//  Purpose  : Self-checking bench for modexp_initiator with a behavioural
//             modexp core (normal / never-done / stale-done modes).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_modexp_initiator;

  localparam int          W    = 32;
  localparam int          TW   = 4;
  localparam int          TMO  = 16;
  localparam int          LAT  = 3;
  localparam logic [63:0] MOD  = 64'd998244353;
  localparam int          M_NORMAL = 0, M_NEVER = 1, M_STALE = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, out_timeout;
  logic me_start, me_done, busy;
  logic [W-1:0]  in_base, in_exp, out_result, me_base, me_exp, me_result;
  logic [TW-1:0] in_tag, out_tag;
  logic [15:0]   jobs_cnt;

  always #5 clk = ~clk;

  modexp_initiator #(.WIDTH(W), .TAG_W(TW), .DEPTH(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_exp(in_exp), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_timeout(out_timeout),
    .me_start(me_start), .me_base(me_base), .me_exp(me_exp),
    .me_done(me_done), .me_result(me_result),
    .busy(busy), .jobs_cnt(jobs_cnt)
  );

  // Reference modular exponentiation
  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e);
    logic [63:0] r;
    logic [63:0] x;
    r = 64'd1;
    x = {32'd0, b} % MOD;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % MOD;
      x = (x * x) % MOD;
    end
    return r[31:0];
  endfunction

  // Behavioural core: done pulses LAT cycles after start; result only valid with done
  int          mode;
  logic        force_done;
  logic [3:0]  lat_cnt;
  logic        norm_done, stale_q;
  logic [31:0] core_res;
  always @(posedge clk) begin
    if (rst) begin
      lat_cnt <= 0; norm_done <= 0; stale_q <= 0; core_res <= 0;
    end else begin
      norm_done <= 1'b0;
      stale_q   <= (mode == M_STALE) && me_start;
      if (me_start) begin
        core_res <= modexp(me_base, me_exp);
        lat_cnt  <= (mode == M_NEVER) ? 4'd0 : 4'(LAT);
      end else if (lat_cnt == 4'd1) begin
        norm_done <= 1'b1;
        lat_cnt   <= 4'd0;
      end else if (lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
    end
  end
  assign me_done   = norm_done || force_done || ((mode == M_STALE) && (me_start || stale_q));
  assign me_result = norm_done ? core_res : 32'hDEAD_BEEF;

  // Scoreboard and bookkeeping
  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        tmo;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, exp_jobs = 0, n_start = 0, cyc = 0, start_cyc = 0;
  logic ov_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every accepted result
  always @(negedge clk) begin
    exp_t e;
    if (me_start) begin
      n_start++;
      start_cyc = cyc;
    end
    if (out_valid && !ov_prev && out_timeout)
      check("tmo_latency", 64'(cyc - start_cyc), 64'd17);
    ov_prev = out_valid;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'(out_tag), 64'hFFFF);
      end else begin
        e = sb.pop_front();
        check("result", 64'(out_result), 64'(e.res));
        check("tag", 64'(out_tag), 64'(e.tag));
        check("timeout_flag", 64'(out_timeout), 64'(e.tmo));
        exp_jobs++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a job, wait for acceptance, record the expected response
  task automatic push_job(input logic [31:0] b, input logic [31:0] e, input logic [3:0] t,
                          input logic [31:0] res, input logic tmo);
    int k;
    exp_t x;
    in_base = b; in_exp = e; in_tag = t; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin step(); k++; end
    if (!in_ready) check("push_accept", 64'(in_ready), 64'd1);
    x.res = res; x.tag = t; x.tmo = tmo;
    sb.push_back(x);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < budget) begin step(); k++; end
    check(name, 64'((sb.size() == 0) && !busy), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    sb.delete();
    exp_jobs = 0;
    rst = 1'b0;
  endtask

  initial begin
    int n0, k;
    logic [31:0] snap_res;
    logic [3:0]  snap_tag;
    logic        stable;

    rst = 1'b1; in_valid = 1'b0; in_base = '0; in_exp = '0; in_tag = '0;
    out_ready = 1'b1; mode = M_NORMAL; force_done = 1'b0;
    repeat (3) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_jobs_cnt", 64'(jobs_cnt), 64'd0);
    check("rst_me_start", 64'(me_start), 64'd0);
    check("rst_me_base", 64'(me_base), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    rst = 1'b0;
    step();

    // Single job
    n0 = n_start;
    push_job(32'd5, 32'd13, 4'd3, 32'd222458772, 1'b0);
    drain("single_drain", 100);
    check("single_starts", 64'(n_start - n0), 64'd1);
    check("single_jobs_cnt", 64'(jobs_cnt), 64'd1);

    // Back-to-back jobs in consecutive cycles
    n0 = n_start;
    push_job(32'd2, 32'd0, 4'd1, 32'd1, 1'b0);
    push_job(32'd2, 32'd10, 4'd2, 32'd1024, 1'b0);
    push_job(32'd998244352, 32'd2, 4'd4, 32'd1, 1'b0);
    push_job(32'd998244352, 32'd3, 4'd8, 32'd998244352, 1'b0);
    drain("b2b_drain", 200);
    check("b2b_starts", 64'(n_start - n0), 64'd4);
    check("b2b_jobs_cnt", 64'(jobs_cnt), 64'd5);

    // Fill with the consumer stalled
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_job(32'(3 + i), 32'(7 + i), 4'(5 + i), modexp(32'(3 + i), 32'(7 + i)), 1'b0);
    in_base = 32'd123456; in_exp = 32'd65537; in_tag = 4'd10; in_valid = 1'b1;
    sb.push_back('{res: modexp(32'd123456, 32'd65537), tag: 4'd10, tmo: 1'b0});
    k = 0;
    while (!out_valid && k < 30) begin step(); k++; end
    check("fill_out_valid", 64'(out_valid), 64'd1);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    snap_res = out_result; snap_tag = out_tag; stable = 1'b1;
    repeat (50) begin
      step();
      if (out_valid !== 1'b1 || out_result !== snap_res || out_tag !== snap_tag || in_ready !== 1'b0)
        stable = 1'b0;
    end
    check("fill_hold_stable", 64'(stable), 64'd1);
    out_ready = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin step(); k++; end
    check("fill_reopen", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    drain("fill_drain", 300);
    check("fill_jobs_cnt", 64'(jobs_cnt), 64'd6);

    // Timeout with a core that never finishes
    mode = M_NEVER;
    push_job(32'd11, 32'd2, 4'd7, 32'd0, 1'b1);
    drain("tmo_drain", 100);
    check("tmo_jobs_cnt", 64'(jobs_cnt), 64'(exp_jobs));

    // Late done after the timeout must be ignored
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    repeat (5) step();
    check("late_out_valid", 64'(out_valid), 64'd0);
    check("late_jobs_cnt", 64'(jobs_cnt), 64'(exp_jobs));
    mode = M_NORMAL;
    push_job(32'd3, 32'd5, 4'd9, 32'd243, 1'b0);
    drain("late_next_drain", 100);

    // Stale done held through ISSUE and the first WAIT cycle
    mode = M_STALE;
    n0 = n_start;
    push_job(32'd7, 32'd3, 4'd10, 32'd343, 1'b0);
    push_job(32'd2, 32'd31, 4'd11, 32'd150994942, 1'b0);
    drain("stale_drain", 200);
    check("stale_starts", 64'(n_start - n0), 64'd2);
    check("stale_jobs_cnt", 64'(jobs_cnt), 64'(exp_jobs));

    // Reset in the middle of WAIT
    mode = M_NEVER;
    n0 = n_start;
    push_job(32'd4, 32'd4, 4'd12, 32'd256, 1'b0);
    k = 0;
    while (n_start == n0 && k < 20) begin step(); k++; end
    check("midrst_issued", 64'(n_start - n0), 64'd1);
    step(); step();
    do_reset();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_jobs_cnt", 64'(jobs_cnt), 64'd0);
    n0 = n_start;
    repeat (20) step();
    check("midrst_no_start", 64'(n_start - n0), 64'd0);
    mode = M_NORMAL;
    push_job(32'd6, 32'd2, 4'd13, 32'd36, 1'b0);
    drain("midrst_next_drain", 100);
    check("midrst_next_cnt", 64'(jobs_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule : tb_modexp_initiator
`default_nettype wire
